// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite scan engine.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int unsigned DEF_SPR_W   = 5;
  localparam int unsigned DEF_SPR_H   = 5;
  localparam int unsigned DEF_NUM_SPR = 4;

  // Ceiling log2, never below 1 so that degenerate dimensions still get a real bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Row/column walker producing the sprite ROM address by increment from a base.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W  = DEF_SPR_W,
  parameter int unsigned SPR_H  = DEF_SPR_H,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned COL_W  = clog2(SPR_W),
  parameter int unsigned ROW_W  = clog2(SPR_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              last_c
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);

  always_comb last_c = (col == COL_LAST) && (row == ROW_LAST);

  // Pixels are stored row-major, so the address simply counts up across row wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (load) begin
      addr <= base;
      col  <= '0;
      row  <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_scan_engine.sv
// Walks one sprite from a synchronous ROM and emits a plot request per visible pixel.
module sprite_scan_engine
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W        = DEF_SPR_W,
  parameter int unsigned SPR_H        = DEF_SPR_H,
  parameter int unsigned NUM_SPR      = DEF_NUM_SPR,
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 7,
  parameter int unsigned COLOR_W      = 3,
  parameter int unsigned TRANSP_EN    = 1,
  parameter int unsigned TRANSP_COLOR = 0,
  localparam int unsigned SEL_W       = clog2(NUM_SPR),
  localparam int unsigned ADDR_W      = clog2(NUM_SPR * SPR_W * SPR_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SEL_W-1:0]   sprite_sel,
  input  logic [X_W-1:0]     base_x,
  input  logic [Y_W-1:0]     base_y,
  input  logic               mirror,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [X_W-1:0]     x_coordinate,
  output logic [Y_W-1:0]     y_coordinate,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int unsigned        COL_W      = clog2(SPR_W);
  localparam int unsigned        ROW_W      = clog2(SPR_H);
  localparam logic [ADDR_W-1:0]  SPR_SIZE   = ADDR_W'(SPR_W * SPR_H);
  localparam logic [X_W-1:0]     X_FLIP     = X_W'(SPR_W - 1);
  localparam logic [COLOR_W-1:0] TRANSP_VAL = COLOR_W'(TRANSP_COLOR);

  scan_state_t state_q, state_d;
  logic               drain_q;
  logic               accept_c, advance_c, last_c;
  logic [ADDR_W-1:0]  base_addr_c;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [X_W-1:0]     base_x_q;
  logic [Y_W-1:0]     base_y_q;
  logic               mirror_q;
  logic               vld1_q;
  logic [COL_W-1:0]   col1_q;
  logic [ROW_W-1:0]   row1_q;
  logic [X_W-1:0]     x_off_c;
  logic               opaque_c;

  assign base_addr_c = ADDR_W'(sprite_sel) * SPR_SIZE;

  sprite_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (accept_c),
    .advance (advance_c),
    .base    (base_addr_c),
    .addr    (rom_addr),
    .col     (col),
    .row     (row),
    .last_c  (last_c)
  );

  // Next-state logic; DRAIN holds two cycles to flush the ROM and output stages.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    advance_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (last_c) state_d = DRAIN;
        else        advance_c = 1'b1;
      end
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      drain_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_x_q <= '0;
      base_y_q <= '0;
      mirror_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) && !drain_q;
      busy    <= (state_d == SCAN) || (state_d == DRAIN);
      done    <= (state_d == DONE);
      if (accept_c) begin
        base_x_q <= base_x;
        base_y_q <= base_y;
        mirror_q <= mirror;
      end
    end
  end

  always_comb begin
    x_off_c  = mirror_q ? (X_FLIP - X_W'(col1_q)) : X_W'(col1_q);
    opaque_c = (TRANSP_EN == 0) || (rom_data != TRANSP_VAL);
  end

  // Row/col ride one stage behind the address so they meet the matching ROM word.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld1_q       <= 1'b0;
      col1_q       <= '0;
      row1_q       <= '0;
      plot         <= 1'b0;
      x_coordinate <= '0;
      y_coordinate <= '0;
      color        <= '0;
    end else begin
      vld1_q <= (state_q == SCAN);
      col1_q <= col;
      row1_q <= row;
      plot   <= vld1_q && opaque_c;
      if (vld1_q && opaque_c) begin
        x_coordinate <= base_x_q + x_off_c;
        y_coordinate <= base_y_q + Y_W'(row1_q);
        color        <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_scan_engine.sv
// Bench for sprite_scan_engine: table of scan jobs, scoreboard of expected plots, reset corner case.
module tb_sprite_scan_engine;

  localparam int N = 25;

  logic       clk = 1'b0;
  logic       reset, start, mirror;
  logic [1:0] sprite_sel;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [6:0] rom_addr;
  logic [2:0] rom_data;
  logic [7:0] x_coordinate;
  logic [6:0] y_coordinate;
  logic [2:0] color;
  logic       plot, busy, done;

  logic [2:0] rom [0:99];

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] bx;
    logic [6:0] by;
    logic       mir;
    bit         zero_even;
    int         restart_k;
    int         exp_count;
    int         exp_addr0;
    int         fx, fy, lx, ly;
  } vec_t;

  plot_t sbq[$];
  vec_t  vecs[5];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    mon_count = 0;
  int    mon_fx, mon_fy, mon_lx, mon_ly;

  sprite_scan_engine #(
    .TRANSP_EN    (1),
    .TRANSP_COLOR (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sprite_sel   (sprite_sel),
    .base_x       (base_x),
    .base_y       (base_y),
    .mirror       (mirror),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .x_coordinate (x_coordinate),
    .y_coordinate (y_coordinate),
    .color        (color),
    .plot         (plot),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_rom(input bit zero_even);
    for (int a = 0; a < 100; a++)
      rom[a] = (zero_even && a < N && (a % 2) == 0) ? 3'd0 : 3'((a % 7) + 1);
  endtask

  task automatic push_expect(input logic [1:0] sel, input logic [7:0] bx, input logic [6:0] by,
                             input logic mir, input int s);
    plot_t e;
    int    a;
    for (int k = 0; k < N; k++) begin
      a = int'(sel) * N + k;
      if (rom[a] != 3'd0) begin
        e.cyc = s + 3 + k;
        e.x   = bx + 8'(mir ? (4 - k % 5) : (k % 5));
        e.y   = by + 7'(k / 5);
        e.c   = rom[a];
        sbq.push_back(e);
      end
    end
  endtask

  // Plot monitor: every plot must match the head of the scoreboard, in its own cycle.
  always @(negedge clk) begin
    plot_t e;
    if (plot) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_plot actual x=%0d y=%0d c=%0d required=no plot (cycle %0d)",
                 x_coordinate, y_coordinate, color, cyc);
      end else begin
        e = sbq.pop_front();
        check("plot_cycle", cyc, e.cyc);
        check("plot_x", int'(x_coordinate), int'(e.x));
        check("plot_y", int'(y_coordinate), int'(e.y));
        check("plot_color", int'(color), int'(e.c));
      end
      if (mon_count == 0) begin
        mon_fx = int'(x_coordinate);
        mon_fy = int'(y_coordinate);
      end
      mon_lx = int'(x_coordinate);
      mon_ly = int'(y_coordinate);
      mon_count++;
    end
  end

  task automatic run_scan(input logic [1:0] sel, input logic [7:0] bx, input logic [6:0] by,
                          input logic mir, input int restart_k, output int first_addr);
    int s;
    bit seen;
    @(negedge clk);
    check("idle_done_low", int'(done), 0);
    check("idle_busy_low", int'(busy), 0);
    start = 1'b1; sprite_sel = sel; base_x = bx; base_y = by; mirror = mir;
    s = cyc;
    mon_count = 0;
    push_expect(sel, bx, by, mir, s);
    first_addr = -1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      if (k == restart_k) begin
        sprite_sel = sel + 2'd1;
        base_x = bx + 8'd7;
      end
      if (k == 0) first_addr = int'(rom_addr);
      check("rom_addr", int'(rom_addr), int'(sel) * N + k);
      check("busy_scan", int'(busy), 1);
      check("no_early_done", int'(done), 0);
    end
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        check("done_cycle", cyc, s + N + 3);
        check("busy_at_done", int'(busy), 0);
        check("sb_left_at_done", sbq.size(), 0);
      end else begin
        check("busy_drain", int'(busy), 1);
        @(negedge clk);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    int a0;
    int s;
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int s;
    reset = 1'b1; start = 1'b0; sprite_sel = '0; base_x = '0; base_y = '0; mirror = 1'b0;
    set_rom(1'b0);
    vecs[0] = '{2'd0, 8'd10,  7'd20,  1'b0, 1'b0, -1, 25, 0,  10,  20,  14, 24};
    vecs[1] = '{2'd2, 8'd0,   7'd0,   1'b1, 1'b0, -1, 25, 50, 4,   0,   0,  4};
    vecs[2] = '{2'd1, 8'd254, 7'd126, 1'b0, 1'b0, -1, 25, 25, 254, 126, 2,  2};
    vecs[3] = '{2'd3, 8'd100, 7'd50,  1'b1, 1'b0, 5,  25, 75, 104, 50,  100, 54};
    vecs[4] = '{2'd0, 8'd10,  7'd20,  1'b0, 1'b1, -1, 12, 0,  11,  20,  13, 24};

    repeat (2) @(negedge clk);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x_coordinate), 0);
    check("rst_y", int'(y_coordinate), 0);
    check("rst_color", int'(color), 0);
    reset = 1'b0;

    // Back-to-back jobs: each start lands in the cycle right after the previous done.
    for (int v = 0; v < 5; v++) begin
      set_rom(vecs[v].zero_even);
      run_scan(vecs[v].sel, vecs[v].bx, vecs[v].by, vecs[v].mir, vecs[v].restart_k, a0);
      check("vec_first_addr", a0, vecs[v].exp_addr0);
      check("vec_plot_count", mon_count, vecs[v].exp_count);
      check("vec_first_x", mon_fx, vecs[v].fx);
      check("vec_first_y", mon_fy, vecs[v].fy);
      check("vec_last_x", mon_lx, vecs[v].lx);
      check("vec_last_y", mon_ly, vecs[v].ly);
    end

    // Reset while pixel 7's address is on the bus.
    set_rom(1'b0);
    @(negedge clk);
    start = 1'b1; sprite_sel = 2'd1; base_x = 8'd30; base_y = 7'd40; mirror = 1'b0;
    s = cyc;
    push_expect(2'd1, 8'd30, 7'd40, 1'b0, s);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_addr", int'(rom_addr), 25 + 7);
    check("pre_rst_cycle", cyc, s + 8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    check("midrst_rom_addr", int'(rom_addr), 0);
    check("midrst_plot", int'(plot), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_x", int'(x_coordinate), 0);
    check("midrst_y", int'(y_coordinate), 0);
    check("midrst_color", int'(color), 0);
    repeat (6) begin
      @(negedge clk);
      check("post_rst_quiet_plot", int'(plot), 0);
    end
    run_scan(2'd1, 8'd30, 7'd40, 1'b0, -1, a0);
    check("post_rst_first_addr", a0, 25);
    check("post_rst_count", mon_count, 25);
    check("post_rst_last_x", mon_lx, 34);
    check("post_rst_last_y", mon_ly, 44);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_scan_engine.md
Name: sprite_scan_engine

Overview:
- Parametrised successor to the fixed 5x5 character scanner.
- On a start pulse, walks a selectable sprite in a synchronous sprite ROM row by row and issues ROM addresses.
- Emits one plot request per non-transparent pixel: screen x/y = base + offset, plus colour, for the VGA adapter.
- Adds sprite select, screen placement, horizontal mirror, transparency skip and a start/busy/done handshake.

Parameters:
- SPR_W, 5, sprite width in pixels (>=1)
- SPR_H, 5, sprite height in pixels (>=1)
- NUM_SPR, 4, number of sprites stored back-to-back in ROM
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- COLOR_W, 3, colour width
- TRANSP_EN, 1, 1 = suppress plot for pixels equal to TRANSP_COLOR
- TRANSP_COLOR, 0, colour value treated as transparent
- ADDR_W, clog2(NUM_SPR*SPR_W*SPR_H), ROM address width (derived localparam)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- sprite_sel  in  clog2(NUM_SPR)  sprite index, latched on accepted start
- base_x  in  X_W  screen x of sprite column 0, latched on start
- base_y  in  Y_W  screen y of sprite row 0, latched on start
- mirror  in  1  1 = horizontal flip, latched on start
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  COLOR_W  ROM output; valid one cycle after rom_addr (synchronous ROM)
- x_coordinate  out  X_W  plot x
- y_coordinate  out  Y_W  plot y
- color  out  COLOR_W  plot colour
- plot  out  1  x/y/color valid this cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of scan

Behaviour:
- Reset: state IDLE. All outputs 0, including rom_addr, coordinates, color, plot, busy and done. Internal row/col counters are 0. Reset overrides everything, including mid-scan; no further plot occurs after reset.
- States: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches sprite_sel, base_x, base_y and mirror.
  - Loads spr_base = sprite_sel*SPR_W*SPR_H, col=0, row=0; goes to SCAN.
  - start is ignored in every other state; no queueing.
- SCAN:
  - Each cycle: rom_addr <= spr_base + row*SPR_W + col, produced by an incrementing address register, not a multiplier.
  - col increments. At col==SPR_W-1, col wraps to 0 and row increments.
  - At the last pixel (row==SPR_H-1, col==SPR_W-1): go to DRAIN.
- DRAIN:
  - Lasts 2 cycles; flushes the ROM and output pipeline stages. No new addresses issued.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done rises.
- Pipeline: row/col travel alongside the address, so each plot pairs with the data for its own address.
  - Address for pixel k is presented in cycle S+1+k, where S is the start cycle.
  - rom_data returns in cycle S+2+k.
  - Registered plot outputs appear in cycle S+3+k.
- Coordinates:
  - x_coordinate = base_x + (mirror ? SPR_W-1-col : col), modulo 2^X_W (wraps, no clamp).
  - y_coordinate = base_y + row, modulo 2^Y_W.
- plot = 1 for every pixel when TRANSP_EN=0. When TRANSP_EN=1, plot = 1 only if rom_data != TRANSP_COLOR.
- On cycles with plot=0, coordinates and color hold their last value.
- Total latency: the done pulse occurs in cycle S + SPR_W*SPR_H + 3.
- The scan is never stalled; downstream must accept one plot per cycle.
- SPR_W=1 or SPR_H=1 are legal. A 1x1 sprite yields one address, then DRAIN.

Decomposition:
- Shared package (sprite_pkg) holds:
  - Scan state enum (IDLE, SCAN, DRAIN, DONE).
  - Default sprite dimension constants.
  - A clog2 helper constant function.
- One natural sub-module: sprite_addr_gen. It holds the row/col counters, address increment, wrap logic and last-pixel flag.
- The top level holds the FSM, the two-stage pipeline and the plot/coordinate arithmetic.

Test Plan:
- Defaults, TRANSP_EN=0; start with sel=0, base=(10,20), mirror=0:
  - 25 plots in consecutive cycles S+3..S+27.
  - First plot is (10,20); (14,20) is followed by (10,21); last is (14,24).
  - rom_addr runs 0..24; done in S+28.
- sel=2, mirror=1, base=(0,0):
  - rom_addr runs 50..74.
  - First plot x=4, then 3,2,1,0 per row; y runs 0..4.
- TRANSP_EN=1, ROM where sprite 0 has only odd addresses nonzero:
  - Exactly 12 plots, each with colour matching its address.
  - done still lands in S+28.
- base_x=254, base_y=126: column 2 plots at x=0; row 2 plots at y=0 (wrap, no error).
- start pulsed again during SCAN: ignored, with exactly one done. Back-to-back start in the cycle after done is accepted.
- reset asserted mid-SCAN at pixel 7: next cycle all outputs are 0 and state is IDLE, with no further plot. A subsequent start runs a full correct scan.
